arp_frame_rx: RTL

GMII receive-side ARP frame parser running in the Ethernet RX clock domain. It locks on preamble and SFD and parses the Ethernet II header and 28-byte ARP payload. It filters on board MAC, board IP and ARP format fields, and checks the FCS. For each accepted frame it presents the sender MAC, sender IP and opcode with a one-cycle completion pulse; the ARP control logic uses these to update the peer address and to schedule replies.

---
 rtl/arp_frame_rx.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/arp_frame_rx.sv
// -----------------------------------------------------------------------------
// arp_frame_rx
//
// GMII receive-side ARP frame parser. Locks on preamble/SFD, walks the
// Ethernet II header and 28-byte ARP payload byte by byte, filters on the
// destination MAC (board or broadcast), the ARP format fields, the opcode and
// the target protocol address, and checks the FCS. Accepted frames publish
// the sender MAC/IP and opcode with a one-cycle arp_rx_end pulse. Frames that
// pass every filter but carry a bad FCS produce a one-cycle crc_err pulse.
//
// Ports
//   clk             GMII RX clock, rising edge
//   rst             synchronous active-high reset
//   gmii_eth_rxctl  receive data valid
//   gmii_eth_rxd    receive byte
//   pc_mac          sender hardware address of the last accepted frame
//   pc_ip           sender protocol address of the last accepted frame
//   arp_op          opcode of the last accepted frame
//   arp_rx_end      pulse: pc_mac/pc_ip/arp_op were just updated
//   crc_err         pulse: frame passed the filters but failed the FCS
//
// State | meaning
//   S_IDLE | waiting for a rising edge of rxctl with a preamble byte
//   S_PRE  | inside the preamble, waiting for the SFD
//   S_BODY | parsing frame bytes after the SFD until rxctl falls
//   S_DROP | malformed preamble, discard until rxctl falls
// -----------------------------------------------------------------------------
module arp_frame_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_eth_rxctl,
  input  logic [7:0]  gmii_eth_rxd,
  output logic [47:0] pc_mac,
  output logic [31:0] pc_ip,
  output logic [15:0] arp_op,
  output logic        arp_rx_end,
  output logic        crc_err
);

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] CNT_MAX     = 11'd2047;
  localparam logic [10:0] MIN_FRAME   = 11'd64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_BODY,
    S_DROP
  } state_t;

  state_t      state, state_nxt;

  logic        rxctl_q;
  logic [10:0] cnt;
  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic        rej;
  logic        miss_board;
  logic        miss_bcast;
  logic [47:0] shadow_mac;
  logic [31:0] shadow_ip;
  logic [15:0] shadow_op;
  logic        acc_pend;
  logic        err_pend;

  logic        sfd_hit;
  logic        body_byte;
  logic        frame_end;
  logic        field_bad;
  logic [7:0]  board_mac_byte;
  logic [7:0]  board_ip_byte;
  logic [1:0]  tpa_idx;
  logic        frame_ok;
  logic        frame_long;

  // Reflected CRC-32, one byte per clock, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c_in,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    sfd_hit   = 1'b0;
    body_byte = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        // Only a rising edge of rxctl may start a frame, so the tail of a
        // frame interrupted by reset is never mistaken for a new preamble.
        if (gmii_eth_rxctl && !rxctl_q && gmii_eth_rxd == 8'h55)
          state_nxt = S_PRE;
      end
      S_PRE: begin
        if (!gmii_eth_rxctl) begin
          state_nxt = S_IDLE;
        end else if (gmii_eth_rxd == 8'hD5) begin
          state_nxt = S_BODY;
          sfd_hit   = 1'b1;
        end else if (gmii_eth_rxd != 8'h55) begin
          state_nxt = S_DROP;
        end
      end
      S_BODY: begin
        if (gmii_eth_rxctl) begin
          body_byte = 1'b1;
        end else begin
          frame_end = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (!gmii_eth_rxctl) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-byte field filter
  // ---------------------------------------------------------------------------
  // Target IP bytes sit at k = 38..41; 38 mod 4 = 2, so subtracting 2 from the
  // low two counter bits gives the byte index within BOARD_IP.
  assign tpa_idx = cnt[1:0] - 2'd2;

  always_comb begin
    board_mac_byte = 8'h00;
    case (cnt[2:0])
      3'd0:    board_mac_byte = BOARD_MAC[47:40];
      3'd1:    board_mac_byte = BOARD_MAC[39:32];
      3'd2:    board_mac_byte = BOARD_MAC[31:24];
      3'd3:    board_mac_byte = BOARD_MAC[23:16];
      3'd4:    board_mac_byte = BOARD_MAC[15:8];
      3'd5:    board_mac_byte = BOARD_MAC[7:0];
      default: board_mac_byte = 8'h00;
    endcase
  end

  always_comb begin
    board_ip_byte = 8'h00;
    case (tpa_idx)
      2'd0:    board_ip_byte = BOARD_IP[31:24];
      2'd1:    board_ip_byte = BOARD_IP[23:16];
      2'd2:    board_ip_byte = BOARD_IP[15:8];
      default: board_ip_byte = BOARD_IP[7:0];
    endcase
  end

  // Fixed-value fields and the opcode. The destination MAC is handled by the
  // two miss flags because either of two addresses is acceptable.
  always_comb begin
    field_bad = 1'b0;
    case (cnt)
      11'd12:  field_bad = (gmii_eth_rxd != 8'h08);
      11'd13:  field_bad = (gmii_eth_rxd != 8'h06);
      11'd14:  field_bad = (gmii_eth_rxd != 8'h00);
      11'd15:  field_bad = (gmii_eth_rxd != 8'h01);
      11'd16:  field_bad = (gmii_eth_rxd != 8'h08);
      11'd17:  field_bad = (gmii_eth_rxd != 8'h00);
      11'd18:  field_bad = (gmii_eth_rxd != 8'h06);
      11'd19:  field_bad = (gmii_eth_rxd != 8'h04);
      11'd20:  field_bad = (gmii_eth_rxd != 8'h00);
      11'd21:  field_bad = (gmii_eth_rxd != 8'h01) && (gmii_eth_rxd != 8'h02);
      11'd38, 11'd39, 11'd40, 11'd41:
               field_bad = (gmii_eth_rxd != board_ip_byte);
      default: field_bad = 1'b0;
    endcase
  end

  assign crc_nxt    = crc32_byte(crc, gmii_eth_rxd);
  assign frame_long = (cnt >= MIN_FRAME);
  assign frame_ok   = !rej && !(miss_board && miss_bcast);

  // ---------------------------------------------------------------------------
  // Datapath: counter, CRC, filters, shadows, outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rxctl_q    <= 1'b1;
      cnt        <= '0;
      crc        <= '1;
      rej        <= 1'b0;
      miss_board <= 1'b0;
      miss_bcast <= 1'b0;
      shadow_mac <= '0;
      shadow_ip  <= '0;
      shadow_op  <= '0;
      acc_pend   <= 1'b0;
      err_pend   <= 1'b0;
      pc_mac     <= '0;
      pc_ip      <= '0;
      arp_op     <= '0;
      arp_rx_end <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      rxctl_q <= gmii_eth_rxctl;

      // End-of-frame decision is registered once, then published one cycle
      // later; the shadows cannot change in between because the next frame
      // needs at least a preamble before reaching the SHA bytes.
      arp_rx_end <= acc_pend;
      crc_err    <= err_pend;
      acc_pend   <= 1'b0;
      err_pend   <= 1'b0;
      if (acc_pend) begin
        pc_mac <= shadow_mac;
        pc_ip  <= shadow_ip;
        arp_op <= shadow_op;
      end

      if (sfd_hit) begin
        cnt        <= '0;
        crc        <= '1;
        rej        <= 1'b0;
        miss_board <= 1'b0;
        miss_bcast <= 1'b0;
      end

      if (body_byte) begin
        if (cnt != CNT_MAX) cnt <= cnt + 11'd1;
        crc <= crc_nxt;
        if (cnt < 11'd6) begin
          if (gmii_eth_rxd != board_mac_byte) miss_board <= 1'b1;
          if (gmii_eth_rxd != 8'hFF)          miss_bcast <= 1'b1;
        end
        if (field_bad) rej <= 1'b1;
        if (cnt == 11'd20 || cnt == 11'd21)
          shadow_op <= {shadow_op[7:0], gmii_eth_rxd};
        if (cnt >= 11'd22 && cnt <= 11'd27)
          shadow_mac <= {shadow_mac[39:0], gmii_eth_rxd};
        if (cnt >= 11'd28 && cnt <= 11'd31)
          shadow_ip <= {shadow_ip[23:0], gmii_eth_rxd};
      end

      if (frame_end) begin
        acc_pend <= frame_long && frame_ok && (crc == CRC_RESIDUE);
        err_pend <= frame_long && frame_ok && (crc != CRC_RESIDUE);
      end
    end
  end

endmodule
